// File: rtl/led_serial_driver_if.sv
// Parallel LED word handshake between the pattern generator and
// led_serial_driver.
//   led_in   : LED word, bit LED_COUNT-1 goes out first
//   in_valid : led_in valid (pattern generator -> driver)
//   in_ready : driver idle, will take a word (driver -> generator)
//   done     : one-cycle pulse at transfer completion (driver -> generator)
// master = pattern generator side, slave = driver side.
interface led_serial_driver_if #(
  parameter int LED_COUNT = 16
) ();
  logic [LED_COUNT-1:0] led_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 done;

  modport master (output led_in, in_valid, input in_ready, done);
  modport slave  (input led_in, in_valid, output in_ready, done);
endinterface

// File: rtl/led_serial_driver.sv
// led_serial_driver: shifts a parallel LED word MSB first into an external
// 74HC595-style chain on a divided serial clock, then strobes the storage
// latch so every LED updates at once.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : led_serial_driver_if slave (led_in/in_valid/in_ready/done)
//   sr_clk     : serial shift clock, CLK_DIV clk cycles per half period
//   sr_data    : serial data, only changes when sr_clk falls (or on accept)
//   sr_latch   : storage latch strobe, high for CLK_DIV cycles
// Optional feature macro LED_SERIAL_SKIP_UNCHANGED_EN: a word identical to
// the last latched one completes at once without touching the chain.
module led_serial_driver #(
  parameter int LED_COUNT = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  led_serial_driver_if.slave  bus,
  output logic                sr_clk,
  output logic                sr_data,
  output logic                sr_latch
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LOAD = IW'(LED_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [IW-1:0]        idx, idx_d;
  logic [LED_COUNT-1:0] sreg, sreg_d;
  logic                 rdy, rdy_d, done_q, done_d;
  logic                 clk_d, data_d, latch_d;
  logic                 skip;

  assign bus.in_ready = rdy;
  assign bus.done     = done_q;

`ifdef LED_SERIAL_SKIP_UNCHANGED_EN
  logic [LED_COUNT-1:0] cap, last;
  logic                 seen;

  assign skip = seen && (bus.led_in == last);

  // last/seen only move when a latch really completes, so an aborted
  // transfer never poisons the comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap  <= '0;
      last <= '0;
      seen <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid && rdy) cap <= bus.led_in;
      if (state == LATCH && cnt == '0) begin
        last <= cap;
        seen <= 1'b1;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sreg     <= '0;
      rdy      <= 1'b1;
      done_q   <= 1'b0;
      sr_clk   <= 1'b0;
      sr_data  <= 1'b0;
      sr_latch <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      sreg     <= sreg_d;
      rdy      <= rdy_d;
      done_q   <= done_d;
      sr_clk   <= clk_d;
      sr_data  <= data_d;
      sr_latch <= latch_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sreg_d  = sreg;
    rdy_d   = rdy;
    done_d  = 1'b0;
    clk_d   = sr_clk;
    data_d  = sr_data;
    latch_d = sr_latch;
    case (state)
      IDLE: begin
        if (bus.in_valid && rdy) begin
          rdy_d = 1'b0;
          if (skip) begin
            // LATCH with a zero count finishes on the next edge; sr_latch
            // is only raised on the SHIFT_HI exit, so it stays low here.
            state_d = LATCH;
            cnt_d   = '0;
          end else begin
            state_d = SHIFT_LO;
            cnt_d   = CNT_LOAD;
            idx_d   = IDX_LOAD;
            sreg_d  = bus.led_in;
            data_d  = bus.led_in[LED_COUNT-1];
          end
        end
      end
      SHIFT_LO: begin
        if (cnt == '0) begin
          clk_d   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt == '0) begin
          clk_d = 1'b0;
          cnt_d = CNT_LOAD;
          if (idx != '0) begin
            // next bit goes out on the falling edge: a full half period of
            // setup and hold around each sr_clk rise
            idx_d   = idx - 1'b1;
            sreg_d  = sreg << 1;
            data_d  = sreg_d[LED_COUNT-1];
            state_d = SHIFT_LO;
          end else begin
            data_d  = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          latch_d = 1'b0;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_led_serial_driver.sv
// Directed bench for led_serial_driver: a 16-LED / div-4 instance and an
// 8-LED / div-1 instance, each feeding a behavioural 595 chain model that
// shifts sr_data on sr_clk rise and copies to its outputs on sr_latch rise.
// Cycle n of a transfer is the clk cycle following accept edge E0 + n.
module tb_led_serial_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  led_serial_driver_if #(.LED_COUNT(16)) bus16 ();
  led_serial_driver_if #(.LED_COUNT(8))  bus8 ();
  logic sr_clk16, sr_data16, sr_latch16;
  logic sr_clk8, sr_data8, sr_latch8;

  led_serial_driver #(.LED_COUNT(16), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave),
    .sr_clk(sr_clk16), .sr_data(sr_data16), .sr_latch(sr_latch16));

  led_serial_driver #(.LED_COUNT(8), .CLK_DIV(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave),
    .sr_clk(sr_clk8), .sr_data(sr_data8), .sr_latch(sr_latch8));

  // chain models
  logic [15:0] chain16 = '0, out16 = '0;
  logic [7:0]  chain8 = '0, out8 = '0;
  int pulses16 = 0, latches16 = 0, pulses8 = 0, latches8 = 0;
  always @(posedge sr_clk16) begin chain16 <= {chain16[14:0], sr_data16}; pulses16 <= pulses16 + 1; end
  always @(posedge sr_latch16) begin out16 <= chain16; latches16 <= latches16 + 1; end
  always @(posedge sr_clk8) begin chain8 <= {chain8[6:0], sr_data8}; pulses8 <= pulses8 + 1; end
  always @(posedge sr_latch8) begin out8 <= chain8; latches8 <= latches8 + 1; end

  int tests = 0, fails = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start16(input logic [15:0] w);
    int t = 0;
    @(negedge clk);
    while (bus16.in_ready !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    if (bus16.in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL start16_ready: in_ready=%b required 1", bus16.in_ready);
    end
    bus16.led_in = w; bus16.in_valid = 1'b1;
  endtask

  task automatic start8(input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    while (bus8.in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (bus8.in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL start8_ready: in_ready=%b required 1", bus8.in_ready);
    end
    bus8.led_in = w; bus8.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    bus16.in_valid = 1'b0; bus16.led_in = '0;
    bus8.in_valid = 1'b0; bus8.led_in = '0;
    rst_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      tests++;
      if ({bus16.in_ready, sr_clk16, sr_data16, sr_latch16, bus16.done} !== 5'b10000) begin
        fails++;
        $display("FAIL reset16 c=%0d: rdy/clk/data/latch/done=%b required 10000", c,
                 {bus16.in_ready, sr_clk16, sr_data16, sr_latch16, bus16.done});
      end
      tests++;
      if ({bus8.in_ready, sr_clk8, sr_data8, sr_latch8, bus8.done} !== 5'b10000) begin
        fails++;
        $display("FAIL reset8 c=%0d: rdy/clk/data/latch/done=%b required 10000", c,
                 {bus8.in_ready, sr_clk8, sr_data8, sr_latch8, bus8.done});
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] w = 16'hA5C3;
    int p0, l0, bad_clk = 0, bad_data = 0, bad_lat = 0, bad_done = 0, bad_rdy = 0;
    logic e_clk, e_data;
    start16(w);
    p0 = pulses16; l0 = latches16;
    for (int n = 0; n <= 140; n++) begin
      @(negedge clk);
      if (n == 0) bus16.in_valid = 1'b0;
      e_clk  = (n < 128) && ((n / 4) % 2 == 1);
      e_data = (n < 128) ? w[15 - n / 8] : 1'b0;
      if (sr_clk16 !== e_clk) bad_clk++;
      if (sr_data16 !== e_data) bad_data++;
      if (sr_latch16 !== (n >= 128 && n <= 131)) bad_lat++;
      if (bus16.done !== (n == 132)) bad_done++;
      if (bus16.in_ready !== (n >= 132)) bad_rdy++;
    end
    tests++; if (bad_clk != 0) begin fails++; $display("FAIL single_sr_clk: %0d bad cycles, required 0", bad_clk); end
    tests++; if (bad_data != 0) begin fails++; $display("FAIL single_sr_data: %0d bad cycles, required 0", bad_data); end
    tests++; if (bad_lat != 0) begin fails++; $display("FAIL single_latch_128_131: %0d bad cycles, required 0", bad_lat); end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL single_done_132: %0d bad cycles, required 0", bad_done); end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL single_in_ready: %0d bad cycles, required 0", bad_rdy); end
    tests++; if (out16 !== 16'hA5C3) begin fails++; $display("FAIL single_chain: got %h required a5c3", out16); end
    tests++; if (pulses16 - p0 != 16) begin fails++; $display("FAIL single_pulses: got %0d required 16", pulses16 - p0); end
    tests++; if (latches16 - l0 != 1) begin fails++; $display("FAIL single_latches: got %0d required 1", latches16 - l0); end
  endtask

  task automatic test_back_to_back();
    int p0, l0, bad_done = 0;
    logic [15:0] mid = '0;
    start16(16'h0001);
    p0 = pulses16; l0 = latches16;
    for (int n = 0; n <= 275; n++) begin
      @(negedge clk);
      if (n == 0) bus16.led_in = 16'h8000;
      if (n == 133) bus16.in_valid = 1'b0;   // second word taken on the edge ending the done cycle
      if (n == 140) mid = out16;
      if (bus16.done !== (n == 132 || n == 265)) bad_done++;
    end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL b2b_done_132_265: %0d bad cycles, required 0", bad_done); end
    tests++; if (mid !== 16'h0001) begin fails++; $display("FAIL b2b_first_word: got %h required 0001", mid); end
    tests++; if (out16 !== 16'h8000) begin fails++; $display("FAIL b2b_second_word: got %h required 8000", out16); end
    tests++; if (pulses16 - p0 != 32) begin fails++; $display("FAIL b2b_pulses: got %0d required 32", pulses16 - p0); end
    tests++; if (latches16 - l0 != 2) begin fails++; $display("FAIL b2b_latches: got %0d required 2", latches16 - l0); end
  endtask

  task automatic test_handshake_ignore();
    int bad_done = 0;
    logic [15:0] mid = '0;
    logic rdy_mid = 1'b1;
    start16(16'h1234);
    for (int n = 0; n <= 275; n++) begin
      @(negedge clk);
      if (n == 3) bus16.led_in = 16'hFFFF;
      if (n == 133) bus16.in_valid = 1'b0;
      if (n == 50) rdy_mid = bus16.in_ready;
      if (n == 132) mid = out16;
      if (bus16.done !== (n == 132 || n == 265)) bad_done++;
    end
    tests++; if (rdy_mid !== 1'b0) begin fails++; $display("FAIL hs_busy_ready: got %b required 0", rdy_mid); end
    tests++; if (mid !== 16'h1234) begin fails++; $display("FAIL hs_first_word: got %h required 1234", mid); end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL hs_done_132_265: %0d bad cycles, required 0", bad_done); end
    tests++; if (out16 !== 16'hFFFF) begin fails++; $display("FAIL hs_second_word: got %h required ffff", out16); end
  endtask

  task automatic test_reset_mid();
    int p0, l0, t = 0, bad_done = 0;
    start16(16'h0F0F);
    p0 = pulses16; l0 = latches16;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    while (pulses16 - p0 < 5 && t < 200) begin @(negedge clk); t++; end
    tests++; if (pulses16 - p0 != 5) begin fails++; $display("FAIL rmid_wait: pulses %0d required 5", pulses16 - p0); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus16.in_ready, sr_clk16, sr_data16, sr_latch16, bus16.done} !== 5'b10000) begin
      fails++;
      $display("FAIL rmid_outputs: rdy/clk/data/latch/done=%b required 10000",
               {bus16.in_ready, sr_clk16, sr_data16, sr_latch16, bus16.done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tests++; if (latches16 != l0) begin fails++; $display("FAIL rmid_no_latch: latches %0d required %0d", latches16, l0); end
    tests++; if (out16 !== 16'hFFFF) begin fails++; $display("FAIL rmid_leds_kept: got %h required ffff", out16); end
    start16(16'h00FF);
    for (int n = 0; n <= 135; n++) begin
      @(negedge clk);
      if (n == 0) bus16.in_valid = 1'b0;
      if (bus16.done !== (n == 132)) bad_done++;
    end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL rmid_next_done: %0d bad cycles, required 0", bad_done); end
    tests++; if (out16 !== 16'h00FF) begin fails++; $display("FAIL rmid_next_word: got %h required 00ff", out16); end
  endtask

  task automatic test_small();
    int p0, l0, bad_lat = 0, bad_done = 0, bad_clk = 0;
    start8(8'h81);
    p0 = pulses8; l0 = latches8;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 0) bus8.in_valid = 1'b0;
      if (sr_clk8 !== (n < 16 && n % 2 == 1)) bad_clk++;
      if (sr_latch8 !== (n == 16)) bad_lat++;
      if (bus8.done !== (n == 17)) bad_done++;
    end
    tests++; if (bad_clk != 0) begin fails++; $display("FAIL small_sr_clk: %0d bad cycles, required 0", bad_clk); end
    tests++; if (bad_lat != 0) begin fails++; $display("FAIL small_latch_16: %0d bad cycles, required 0", bad_lat); end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL small_done_17: %0d bad cycles, required 0", bad_done); end
    tests++; if (pulses8 - p0 != 8) begin fails++; $display("FAIL small_pulses: got %0d required 8", pulses8 - p0); end
    tests++; if (out8 !== 8'h81) begin fails++; $display("FAIL small_word: got %h required 81", out8); end
  endtask

  task automatic test_resend();
    int p0, l0, bad_done = 0, bad_rdy = 0, clk_hi = 0;
    start8(8'h81);
    p0 = pulses8; l0 = latches8;
`ifdef LED_SERIAL_SKIP_UNCHANGED_EN
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      if (n == 0) bus8.in_valid = 1'b0;
      if (sr_clk8 !== 1'b0 || sr_latch8 !== 1'b0) clk_hi++;
      if (bus8.done !== (n == 1)) bad_done++;
      if (bus8.in_ready !== (n >= 1)) bad_rdy++;
    end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL skip_done_e1: %0d bad cycles, required 0", bad_done); end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL skip_ready_e1: %0d bad cycles, required 0", bad_rdy); end
    tests++; if (clk_hi != 0) begin fails++; $display("FAIL skip_quiet: %0d active cycles, required 0", clk_hi); end
    tests++; if (pulses8 != p0) begin fails++; $display("FAIL skip_pulses: got %0d required 0", pulses8 - p0); end
`else
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 0) bus8.in_valid = 1'b0;
      if (sr_latch8 !== (n == 16)) clk_hi++;
      if (bus8.done !== (n == 17)) bad_done++;
      if (bus8.in_ready !== (n >= 17)) bad_rdy++;
    end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL resend_done_17: %0d bad cycles, required 0", bad_done); end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL resend_ready: %0d bad cycles, required 0", bad_rdy); end
    tests++; if (clk_hi != 0) begin fails++; $display("FAIL resend_latch_16: %0d bad cycles, required 0", clk_hi); end
    tests++; if (pulses8 - p0 != 8) begin fails++; $display("FAIL resend_pulses: got %0d required 8", pulses8 - p0); end
`endif
    tests++; if (out8 !== 8'h81) begin fails++; $display("FAIL resend_word: got %h required 81", out8); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_handshake_ignore();
    test_reset_mid();
    test_small();
    test_resend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
